// File: rtl/instr_encoder.sv
// instr_encoder: packs one symbolic instruction per handshake into the 32-bit
// ISA word and streams it to sequential imem addresses through a one-deep
// registered write stage. Tracks how many words were accepted since reset/clear.
module instr_encoder #(
  parameter int                 ADDR_W = 12,
  parameter int                 DEPTH  = 4096,
  parameter logic [ADDR_W-1:0]  BASE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [16:0]       imm,
  input  logic [26:0]       target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_SLL  = 4'd4,  OP_SRA  = 4'd5,  OP_ADDI = 4'd6,  OP_LW   = 4'd7,
    OP_SW   = 4'd8,  OP_BNE  = 4'd9,  OP_BLT  = 4'd10, OP_J    = 4'd11,
    OP_JAL  = 4'd12, OP_JR   = 4'd13, OP_BEX  = 4'd14, OP_SETX = 4'd15
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [16:0] imm;
    logic [26:0] target;
  } req_t;

  // ISA major opcodes, bits [31:27]
  localparam logic [4:0] OPC_R    = 5'b00000;
  localparam logic [4:0] OPC_J    = 5'b00001;
  localparam logic [4:0] OPC_BNE  = 5'b00010;
  localparam logic [4:0] OPC_JAL  = 5'b00011;
  localparam logic [4:0] OPC_JR   = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_BLT  = 5'b00110;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_LW   = 5'b01000;
  localparam logic [4:0] OPC_SETX = 5'b10101;
  localparam logic [4:0] OPC_BEX  = 5'b10110;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // Pure encoder: every op_sel code is legal, so there is no error path.
  // ALU op for R-type equals op_sel (0..5) zero-extended to 5 bits.
  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    w = '0;
    case (r.op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:
        w = {OPC_R, r.rd, r.rs, r.rt, 5'b0, {1'b0, r.op}, 2'b00};
      OP_SLL, OP_SRA:
        w = {OPC_R, r.rd, r.rs, 5'b0, r.shamt, {1'b0, r.op}, 2'b00};
      OP_ADDI: w = {OPC_ADDI, r.rd, r.rs, r.imm};
      OP_LW:   w = {OPC_LW,   r.rd, r.rs, r.imm};
      OP_SW:   w = {OPC_SW,   r.rd, r.rs, r.imm};
      OP_BNE:  w = {OPC_BNE,  r.rd, r.rs, r.imm};
      OP_BLT:  w = {OPC_BLT,  r.rd, r.rs, r.imm};
      OP_J:    w = {OPC_J,    r.target};
      OP_JAL:  w = {OPC_JAL,  r.target};
      OP_BEX:  w = {OPC_BEX,  r.target};
      OP_SETX: w = {OPC_SETX, r.target};
      OP_JR:   w = {OPC_JR,   r.rd, 22'b0};
      default: w = '0;
    endcase
    return w;
  endfunction

  req_t              req;
  logic              accept;
  logic [ADDR_W-1:0] ptr;

  // Bundle the request fields so the encoder sees one typed value
  always_comb begin
    req        = '0;
    req.op     = op_e'(op_sel);
    req.rd     = rd;
    req.rs     = rs;
    req.rt     = rt;
    req.shamt  = shamt;
    req.imm    = imm;
    req.target = target;
  end

  // Accept only when the output register is free or draining this cycle
  assign full     = (count == DEPTH_C);
  assign in_ready = ~full & ~clear & (~wr_en | wr_ready);
  assign accept   = in_valid & in_ready;

  // Write stage, address pointer and fill count. The pointer wraps
  // naturally at 2^ADDR_W; only count is bounded by DEPTH via full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ptr     <= BASE;
      count   <= '0;
    end else if (clear) begin
      wr_en   <= 1'b0;
      ptr     <= BASE;
      count   <= '0;
    end else if (accept) begin
      wr_en   <= 1'b1;
      wr_addr <= ptr;
      wr_data <= encode(req);
      ptr     <= ptr + 1'b1;
      count   <= count + 1'b1;
    end else if (wr_en & wr_ready) begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected (addr, word)
// pairs on accept, an independent monitor pops them on each imem write.
module tb_instr_encoder;
  localparam int          AW = 12;
  localparam int          DP = 6;
  localparam logic [11:0] BS = 12'hFFD;

  logic          clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [3:0]    op_sel = '0;
  logic [4:0]    rd = '0, rs = '0, rt = '0, shamt = '0;
  logic [16:0]   imm = '0;
  logic [26:0]   target = '0;
  logic          wr_en, wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          full;

  int tests = 0, errors = 0;
  logic [AW+31:0] q[$];

  // reference-model state
  bit            pend;
  int            cnt;
  logic [AW-1:0] ptr;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DP), .BASE(BS)) dut (
    .clock(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt),
    .imm(imm), .target(target),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the ISA tables with plain arithmetic
  function automatic logic [31:0] model_enc(input int op, input int d, input int s, input int t,
                                            input int sh, input int im, input int tg);
    int unsigned opc [16] = '{0, 0, 0, 0, 0, 0, 5, 8, 7, 2, 6, 1, 3, 4, 22, 21};
    longint unsigned w;
    w = longint'(opc[op]) * 64'd134217728;               // << 27
    if (op <= 5) begin
      if (op >= 4) w += longint'(sh) * 128;                // shifts keep shamt, drop rt
      else         w += longint'(t) * 4096;                // others keep rt, drop shamt
      w += longint'(d) * 4194304 + longint'(s) * 131072 + longint'(op) * 4;
    end else if (op <= 10) w += longint'(d) * 4194304 + longint'(s) * 131072 + longint'(im);
    else if (op == 13)     w += longint'(d) * 4194304;
    else                   w += longint'(tg);
    return w[31:0];
  endfunction

  function automatic void model_reset();
    pend = 0; cnt = 0; ptr = BS; q.delete();
  endfunction

  // One clock of stimulus: compare control outputs, push expected word on accept
  task automatic cyc(input bit use_exp = 0, input logic [31:0] exp_w = '0);
    bit rdy, acc;
    @(negedge clk);
    rdy = (cnt < DP) && !clear && (!pend || wr_ready);
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("count", 64'(count), 64'(cnt));
    check("full", 64'(full), 64'(cnt == DP));
    check("wr_en", 64'(wr_en), 64'(pend));
    acc = in_valid && rdy;
    if (acc)
      q.push_back({ptr, use_exp ? exp_w
                   : model_enc(op_sel, rd, rs, rt, shamt, imm, target)});
    @(posedge clk);
    if (clear) begin pend = 0; ptr = BS; cnt = 0; q.delete(); end
    else if (acc) begin pend = 1; ptr = ptr + 1'b1; cnt++; end
    else if (pend && wr_ready) pend = 0;
    #1;
  endtask

  task automatic set_req(input int op, input int d, input int s, input int t,
                         input int sh, input int im, input int tg);
    op_sel = 4'(op); rd = 5'(d); rs = 5'(s); rt = 5'(t); shamt = 5'(sh);
    imm = 17'(im); target = 27'(tg);
  endtask

  // Monitor: every presented word must match the scoreboard head, popped on write
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (q.size() == 0) begin
        tests++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard", wr_addr, wr_data);
      end else begin
        check("wr_addr", 64'(wr_addr), 64'(q[0][AW+31:32]));
        check("wr_data", 64'(wr_data), 64'(q[0][31:0]));
        if (wr_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check("rst_wr_en", 64'(wr_en), 0);
    check("rst_wr_addr", 64'(wr_addr), 0);
    check("rst_wr_data", 64'(wr_data), 0);
    check("rst_count", 64'(count), 0);
    check("rst_full", 64'(full), 0);
    @(posedge clk); #1 reset = 1'b0;

    // directed words with known encodings, wrapping through 0xFFF -> 0x000
    in_valid = 1; wr_ready = 1;
    set_req(0, 3, 1, 2, 9, 0, 0);      cyc(1, 32'h00C22000);
    set_req(6, 1, 0, 0, 0, 5, 0);      cyc(1, 32'h28400005);
    set_req(4, 4, 5, 7, 3, 0, 0);      cyc(1, 32'h010A0190);
    set_req(13, 31, 0, 0, 0, 0, 0);    cyc(1, 32'h27C00000);
    set_req(11, 0, 0, 0, 0, 0, 'h100); cyc(1, 32'h08000100);
    in_valid = 0; clear = 1; cyc();
    clear = 0; in_valid = 1;
    set_req(8, 0, 0, 0, 0, 0, 0);      cyc(1, 32'h38000000);
    set_req(14, 0, 0, 0, 0, 0, 0);     cyc(1, 32'hB0000000);
    set_req(15, 0, 0, 0, 0, 0, 0);     cyc(1, 32'hA8000000);
    in_valid = 0; repeat (2) cyc();

    // randomized traffic: backpressure, fill to full, occasional clear
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 9) < 7);
      clear    = ($urandom_range(0, 24) == 0);
      set_req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 131071),
              $urandom_range(0, 134217727));
      cyc();
    end

    // reset mid-stream with a stalled word pending and count 2
    clear = 1; in_valid = 0; cyc();
    clear = 0; wr_ready = 0; in_valid = 1;
    set_req(1, 2, 3, 4, 5, 0, 0); cyc();
    wr_ready = 1; set_req(5, 6, 7, 8, 9, 0, 0); cyc();
    wr_ready = 0; in_valid = 0; cyc();
    check("pre_rst_count", 64'(count), 2);
    check("pre_rst_wr_en", 64'(wr_en), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_wr_en", 64'(wr_en), 0);
    check("async_rst_count", 64'(count), 0);
    check("async_rst_wr_data", 64'(wr_data), 0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    wr_ready = 1; in_valid = 1;
    set_req(8, 0, 0, 0, 0, 0, 0);  cyc(1, 32'h38000000);
    set_req(14, 0, 0, 0, 0, 0, 0); cyc(1, 32'hB0000000);
    set_req(15, 0, 0, 0, 0, 0, 0); cyc(1, 32'hA8000000);

    in_valid = 0; repeat (3) cyc();
    check("scoreboard_drained", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
